// File: rtl/alu_isa_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_isa_pkg
// Purpose  : Shared ISA definitions for the operand stage and the ALU: field
//            layout of the 16-bit instruction, opcode / ext encodings, datapath
//            constants and the small decode helpers both blocks agree on.
// Ports    : none (package)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package alu_isa_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int REG_ADDR_W = 4;
   localparam int NUM_REGS   = 16;
   localparam int CTL_WIDTH  = 8;

   typedef logic [3:0]            opcode_t;
   typedef logic [3:0]            ext_t;
   typedef logic [REG_ADDR_W-1:0] regaddr_t;

   // Instruction word layout: opcode | Rdest | ext | Rsrc  (imm8 = {ext, Rsrc})
   typedef struct packed {
      opcode_t  opcode;
      regaddr_t rdest;
      ext_t     ext;
      regaddr_t rsrc;
   } instr_t;

   // Opcodes
   localparam opcode_t OP_RTYPE     = 4'b0000;
   localparam opcode_t OP_ANDI      = 4'b0001;
   localparam opcode_t OP_ORI       = 4'b0010;
   localparam opcode_t OP_XORI      = 4'b0011;
   localparam opcode_t OP_MEMANDJMP = 4'b0100;
   localparam opcode_t OP_ADDI      = 4'b0101;
   localparam opcode_t OP_ADDUI     = 4'b0110;
   localparam opcode_t OP_SHIFT     = 4'b1000;
   localparam opcode_t OP_SUBI      = 4'b1001;
   localparam opcode_t OP_CMPI      = 4'b1011;
   localparam opcode_t OP_BCOND     = 4'b1100;
   localparam opcode_t OP_MOVI      = 4'b1101;
   localparam opcode_t OP_LUI       = 4'b1111;

   // RTYPE ext codes
   localparam ext_t EXT_AND   = 4'b0001;
   localparam ext_t EXT_OR    = 4'b0010;
   localparam ext_t EXT_XOR   = 4'b0011;
   localparam ext_t EXT_ADD   = 4'b0101;
   localparam ext_t EXT_ADDU  = 4'b0110;
   localparam ext_t EXT_SUB   = 4'b1001;
   localparam ext_t EXT_CMP   = 4'b1011;
   localparam ext_t EXT_MOV   = 4'b1101;

   // SHIFT-opcode ext codes
   localparam ext_t EXT_LSH   = 4'b0100;
   localparam ext_t EXT_STORI = 4'b0101;
   localparam ext_t EXT_ASH   = 4'b0110;

   // MEMANDJMP ext codes
   localparam ext_t EXT_LOAD  = 4'b0000;
   localparam ext_t EXT_STORE = 4'b0100;
   localparam ext_t EXT_JCOND = 4'b1100;

   // Sub-classes of the SHIFT opcode, which decide the operand routing
   typedef enum logic [1:0] {
      SHK_REG   = 2'd0,   // shift amount in a register
      SHK_IMM   = 2'd1,   // shift amount encoded in the instruction
      SHK_STORI = 2'd2    // store-immediate shares the opcode
   } shift_kind_t;

   // Opcodes whose destination operand is an extended imm8
   function automatic logic is_imm_op(input opcode_t op);
      case (op)
         OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_ADDUI,
         OP_SUBI, OP_CMPI, OP_MOVI, OP_LUI: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

   function automatic logic imm_is_signed(input opcode_t op);
      case (op)
         OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic writes_rdest(input opcode_t op, input ext_t ext);
      case (op)
         OP_RTYPE:     return (ext != EXT_CMP);
         OP_CMPI:      return 1'b0;
         OP_SHIFT:     return (ext != EXT_STORI);
         OP_MEMANDJMP: return !((ext == EXT_STORE) || (ext == EXT_JCOND));
         OP_BCOND:     return 1'b0;
         default:      return 1'b1;
      endcase
   endfunction

   // Unlisted SHIFT ext codes are routed like an immediate shift
   function automatic shift_kind_t shift_kind(input ext_t ext);
      if ((ext == EXT_LSH) || (ext == EXT_ASH))
         return SHK_REG;
      else if (ext == EXT_STORI)
         return SHK_STORI;
      else
         return SHK_IMM;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_16x.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : reg_file_16x
// Purpose  : General-purpose register file, one synchronous write port and two
//            combinational read ports. Reads return registered contents only;
//            any write-to-read forwarding is done by the instantiating stage.
// Ports    : clk      in   clock
//            reset_n  in   asynchronous active-low reset, clears every entry
//            we       in   write enable
//            waddr    in   write address
//            wdata    in   write data
//            raddr_a  in   read port A address
//            rdata_a  out  read port A data
//            raddr_b  in   read port B address
//            rdata_b  out  read port B data
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module reg_file_16x
   import alu_isa_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int NREGS = NUM_REGS
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [REG_ADDR_W-1:0] raddr_a,
   output logic [WIDTH-1:0]      rdata_a,
   input  logic [REG_ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]      rdata_b
);

   logic [WIDTH-1:0] r_mem [NREGS];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata_a = r_mem[raddr_a];
   assign rdata_b = r_mem[raddr_b];

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_operand_stage
// Purpose  : Issue stage in front of the ALU. Decodes one instruction per
//            valid/ready handshake, reads the register file, extends the
//            immediate and registers the ALU operands. A per-register pending
//            scoreboard (set on issue of a writing instruction, cleared by
//            writeback or by flushing the held instruction) stalls
//            read-after-write hazards.
// Config   : ALU_OPERAND_BYPASS_EN - when defined, a read of the register being
//            written back this cycle takes wbData and is not treated as
//            pending, so a dependent instruction issues in the writeback cycle.
// Ports    : clk               in   clock
//            reset_n           in   asynchronous active-low reset
//            instr             in   instruction word
//            instrValid        in   instr is valid
//            instrReady        out  stage accepts instr this cycle
//            flush             in   drop the held output instruction
//            outReady          in   downstream consumes the output
//            outValid          out  output operands valid
//            aluEnable         out  copy of outValid
//            operationControl  out  {opcode, ext}, ext zeroed for immediates
//            sourceData        out  ALU source operand
//            destData          out  ALU destination operand
//            outDestAddr       out  Rdest of the held instruction
//            outWrites         out  held instruction writes Rdest
//            wbEn/wbAddr/wbData in register-file write port
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module alu_operand_stage
   import alu_isa_pkg::*;
#(
   parameter int WIDTH   = DATA_WIDTH,
   parameter int CTL_LEN = CTL_WIDTH,
   parameter int NREGS   = NUM_REGS
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [15:0]           instr,
   input  logic                  instrValid,
   output logic                  instrReady,
   input  logic                  flush,
   input  logic                  outReady,
   output logic                  outValid,
   output logic                  aluEnable,
   output logic [CTL_LEN-1:0]    operationControl,
   output logic [WIDTH-1:0]      sourceData,
   output logic [WIDTH-1:0]      destData,
   output logic [REG_ADDR_W-1:0] outDestAddr,
   output logic                  outWrites,
   input  logic                  wbEn,
   input  logic [REG_ADDR_W-1:0] wbAddr,
   input  logic [WIDTH-1:0]      wbData
);

   instr_t                w_f;
   logic [7:0]            w_imm8;
   logic [WIDTH-1:0]      w_rf_a;      // R[Rdest] from the register file
   logic [WIDTH-1:0]      w_rf_b;      // R[Rsrc]  from the register file
   logic [WIDTH-1:0]      w_rd_a;
   logic [WIDTH-1:0]      w_rd_b;
   logic [WIDTH-1:0]      w_imm_ext;
   logic [WIDTH-1:0]      w_imm_zext;
   logic [WIDTH-1:0]      w_src;
   logic [WIDTH-1:0]      w_dst;
   logic [3:0]            w_ext_out;
   logic                  w_use_a;
   logic                  w_use_b;
   logic                  w_writes;
   logic                  w_hazard;
   logic                  w_ready;
   logic                  w_fire;
   logic [NREGS-1:0]      w_pend_eff;
   logic [NREGS-1:0]      w_wb_clr;
   logic [NREGS-1:0]      w_flush_clr;
   logic [NREGS-1:0]      w_set;

   logic [NREGS-1:0]      r_pending;
   logic                  r_valid;
   logic [CTL_LEN-1:0]    r_ctl;
   logic [WIDTH-1:0]      r_src;
   logic [WIDTH-1:0]      r_dst;
   logic [REG_ADDR_W-1:0] r_dest;
   logic                  r_writes;

   assign w_f    = instr_t'(instr);
   assign w_imm8 = instr[7:0];

   //---------------------------------------------------------------------------
   // Register file: port A always reads Rdest, port B always reads Rsrc
   //---------------------------------------------------------------------------
   reg_file_16x #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_reg_file (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wbEn),
      .waddr   (wbAddr),
      .wdata   (wbData),
      .raddr_a (w_f.rdest),
      .rdata_a (w_rf_a),
      .raddr_b (w_f.rsrc),
      .rdata_b (w_rf_b)
   );

   assign w_wb_clr = wbEn ? (NREGS'(1) << wbAddr) : '0;

`ifdef ALU_OPERAND_BYPASS_EN
   // Forward the writeback value and hide the bit it is about to clear
   assign w_rd_a     = (wbEn && (wbAddr == w_f.rdest)) ? wbData : w_rf_a;
   assign w_rd_b     = (wbEn && (wbAddr == w_f.rsrc))  ? wbData : w_rf_b;
   assign w_pend_eff = r_pending & ~w_wb_clr;
`else
   assign w_rd_a     = w_rf_a;
   assign w_rd_b     = w_rf_b;
   assign w_pend_eff = r_pending;
`endif

   //---------------------------------------------------------------------------
   // Decode: operand routing, immediate extension, register usage
   //---------------------------------------------------------------------------
   assign w_imm_zext = {{(WIDTH-8){1'b0}}, w_imm8};
   assign w_imm_ext  = imm_is_signed(w_f.opcode) ? {{(WIDTH-8){w_imm8[7]}}, w_imm8}
                                                 : w_imm_zext;
   assign w_writes   = writes_rdest(w_f.opcode, w_f.ext);

   always_comb begin
      w_src     = '0;
      w_dst     = '0;
      w_use_a   = 1'b0;
      w_use_b   = 1'b0;
      w_ext_out = w_f.ext;
      case (w_f.opcode)
         OP_RTYPE: begin
            w_src   = w_rd_b;
            w_dst   = w_rd_a;
            w_use_a = 1'b1;
            w_use_b = 1'b1;
         end
         OP_SHIFT: begin
            case (shift_kind(w_f.ext))
               SHK_REG: begin
                  w_src   = w_rd_a;
                  w_dst   = w_rd_b;
                  w_use_a = 1'b1;
                  w_use_b = 1'b1;
               end
               SHK_STORI: begin
                  w_src   = w_imm_zext;
                  w_dst   = w_rd_a;
                  w_use_a = 1'b1;
               end
               default: begin
                  w_src   = w_rd_a;
                  w_use_a = 1'b1;
               end
            endcase
         end
         OP_MEMANDJMP: begin
            w_src   = w_rd_a;
            w_dst   = w_rd_b;
            w_use_a = 1'b1;
            w_use_b = 1'b1;
         end
         default: begin
            // Immediate class; BCOND and unassigned opcodes read no registers
            // and present zero operands.
            if (is_imm_op(w_f.opcode)) begin
               w_src     = w_rd_a;
               w_dst     = w_imm_ext;
               w_use_a   = 1'b1;
               w_ext_out = 4'b0000;
            end
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Handshake and hazard detection
   //---------------------------------------------------------------------------
   assign w_hazard = instrValid &
                     ((w_use_a & w_pend_eff[w_f.rdest]) |
                      (w_use_b & w_pend_eff[w_f.rsrc]));
   assign w_ready  = (!r_valid || outReady) && !w_hazard && !flush;
   assign w_fire   = instrValid && w_ready;

   //---------------------------------------------------------------------------
   // Pending scoreboard: a set in the same cycle as a clear of that bit wins
   //---------------------------------------------------------------------------
   assign w_set       = (w_fire && w_writes) ? (NREGS'(1) << w_f.rdest) : '0;
   // A flushed instruction will never write back, so release its register
   assign w_flush_clr = (flush && r_valid && r_writes) ? (NREGS'(1) << r_dest) : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~(w_wb_clr | w_flush_clr)) | w_set;
      end
   end

   //---------------------------------------------------------------------------
   // Output register; flush has priority over both a new issue and outReady
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid  <= 1'b0;
         r_ctl    <= '0;
         r_src    <= '0;
         r_dst    <= '0;
         r_dest   <= '0;
         r_writes <= 1'b0;
      end else if (flush) begin
         r_valid  <= 1'b0;
      end else if (w_fire) begin
         r_valid  <= 1'b1;
         r_ctl    <= CTL_LEN'({w_f.opcode, w_ext_out});
         r_src    <= w_src;
         r_dst    <= w_dst;
         r_dest   <= w_f.rdest;
         r_writes <= w_writes;
      end else if (outReady) begin
         r_valid  <= 1'b0;
      end
   end

   assign instrReady       = w_ready;
   assign outValid         = r_valid;
   assign aluEnable        = r_valid;
   assign operationControl = r_ctl;
   assign sourceData       = r_src;
   assign destData         = r_dst;
   assign outDestAddr      = r_dest;
   assign outWrites        = r_writes;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_alu_operand_stage
// Purpose  : Self-checking bench for alu_operand_stage: a table of decode
//            vectors plus hand-written hazard, backpressure, flush and
//            asynchronous-reset sequences. Honours ALU_OPERAND_BYPASS_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] instr;
   logic        instrValid;
   logic        instrReady;
   logic        flush;
   logic        outReady;
   logic        outValid;
   logic        aluEnable;
   logic [7:0]  operationControl;
   logic [15:0] sourceData;
   logic [15:0] destData;
   logic [3:0]  outDestAddr;
   logic        outWrites;
   logic        wbEn;
   logic [3:0]  wbAddr;
   logic [15:0] wbData;

   int total = 0;
   int bad   = 0;

   logic [15:0] rf_model [16];

   typedef struct packed {
      logic [15:0] ins;
      logic [7:0]  ctl;
      logic [15:0] src;
      logic [15:0] dst;
      logic        wr;
      logic        chk_ops;
   } vec_t;

   vec_t vecs [19];

   alu_operand_stage dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .instr            (instr),
      .instrValid       (instrValid),
      .instrReady       (instrReady),
      .flush            (flush),
      .outReady         (outReady),
      .outValid         (outValid),
      .aluEnable        (aluEnable),
      .operationControl (operationControl),
      .sourceData       (sourceData),
      .destData         (destData),
      .outDestAddr      (outDestAddr),
      .outWrites        (outWrites),
      .wbEn             (wbEn),
      .wbAddr           (wbAddr),
      .wbData           (wbData)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeback(input logic [3:0] a, input logic [15:0] d);
      wbEn   = 1'b1;
      wbAddr = a;
      wbData = d;
      rf_model[a] = d;
      tick();
      wbEn = 1'b0;
   endtask

   task automatic check_out(input string nm, input logic [7:0] ctl,
                            input logic [15:0] src, input logic [15:0] dst);
      check({nm, " outValid"}, {31'd0, outValid}, 32'd1);
      check({nm, " aluEnable"}, {31'd0, aluEnable}, 32'd1);
      check({nm, " ctl"}, {24'd0, operationControl}, {24'd0, ctl});
      check({nm, " src"}, {16'd0, sourceData}, {16'd0, src});
      check({nm, " dst"}, {16'd0, destData}, {16'd0, dst});
   endtask

   initial begin
      // Operand expectations assume R2=1, R3=7, R4=2, every other Rn=16'h1100+n
      vecs[0]  = '{16'h0354, 8'h05, 16'h0002, 16'h0007, 1'b1, 1'b1}; // ADD R4,R3
      vecs[1]  = '{16'h52FD, 8'h50, 16'h0001, 16'hFFFD, 1'b1, 1'b1}; // ADDI R2,#-3
      vecs[2]  = '{16'h12FD, 8'h10, 16'h0001, 16'h00FD, 1'b1, 1'b1}; // ANDI R2,#FD
      vecs[3]  = '{16'h03B4, 8'h0B, 16'h0002, 16'h0007, 1'b0, 1'b1}; // CMP R4,R3
      vecs[4]  = '{16'hB380, 8'hB0, 16'h0007, 16'hFF80, 1'b0, 1'b1}; // CMPI R3,#80
      vecs[5]  = '{16'hD57F, 8'hD0, 16'h1105, 16'h007F, 1'b1, 1'b1}; // MOVI R5,#7F
      vecs[6]  = '{16'hF680, 8'hF0, 16'h1106, 16'h0080, 1'b1, 1'b1}; // LUI R6,#80
      vecs[7]  = '{16'h8748, 8'h84, 16'h1107, 16'h1108, 1'b1, 1'b1}; // LSH R7,R8
      vecs[8]  = '{16'h8712, 8'h81, 16'h1107, 16'h0000, 1'b1, 1'b1}; // shift-imm R7
      vecs[9]  = '{16'h895A, 8'h85, 16'h005A, 16'h1109, 1'b0, 1'b1}; // STORI R9
      vecs[10] = '{16'h4104, 8'h40, 16'h1101, 16'h0002, 1'b1, 1'b1}; // LOAD R1,[R4]
      vecs[11] = '{16'h4344, 8'h44, 16'h0007, 16'h0002, 1'b0, 1'b1}; // STORE
      vecs[12] = '{16'h43C4, 8'h4C, 16'h0007, 16'h0002, 1'b0, 1'b1}; // JCOND
      vecs[13] = '{16'h9281, 8'h90, 16'h0001, 16'hFF81, 1'b1, 1'b1}; // SUBI R2,#-127
      vecs[14] = '{16'h62FF, 8'h60, 16'h0001, 16'h00FF, 1'b1, 1'b1}; // ADDUI R2,#FF
      vecs[15] = '{16'h3281, 8'h30, 16'h0001, 16'h0081, 1'b1, 1'b1}; // XORI R2,#81
      vecs[16] = '{16'h2280, 8'h20, 16'h0001, 16'h0080, 1'b1, 1'b1}; // ORI R2,#80
      vecs[17] = '{16'hC3AB, 8'hCA, 16'h0000, 16'h0000, 1'b0, 1'b0}; // BCOND
      vecs[18] = '{16'h8968, 8'h86, 16'h1109, 16'h1108, 1'b1, 1'b1}; // ASH R9,R8

      reset_n = 1'b0; instr = '0; instrValid = 1'b0; flush = 1'b0;
      outReady = 1'b1; wbEn = 1'b0; wbAddr = '0; wbData = '0;
      for (int i = 0; i < 16; i++) rf_model[i] = '0;

      // Reset state
      #12;
      check("rst outValid",  {31'd0, outValid}, 32'd0);
      check("rst aluEnable", {31'd0, aluEnable}, 32'd0);
      check("rst ctl",       {24'd0, operationControl}, 32'd0);
      check("rst src",       {16'd0, sourceData}, 32'd0);
      check("rst dst",       {16'd0, destData}, 32'd0);
      check("rst outWrites", {31'd0, outWrites}, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // Preload the register file
      for (int i = 0; i < 16; i++) begin
         writeback(4'(i), (i == 2) ? 16'h0001 : (i == 3) ? 16'h0007 :
                          (i == 4) ? 16'h0002 : 16'h1100 + 16'(i));
      end
      tick();

      // Table-driven decode vectors
      for (int i = 0; i < 19; i++) begin
         instr = vecs[i].ins; instrValid = 1'b1; outReady = 1'b1;
         #1;
         check($sformatf("v%0d instrReady", i), {31'd0, instrReady}, 32'd1);
         tick();
         instrValid = 1'b0;
         check($sformatf("v%0d outValid", i), {31'd0, outValid}, 32'd1);
         check($sformatf("v%0d ctl", i), {24'd0, operationControl}, {24'd0, vecs[i].ctl});
         check($sformatf("v%0d outWrites", i), {31'd0, outWrites}, {31'd0, vecs[i].wr});
         check($sformatf("v%0d outDestAddr", i), {28'd0, outDestAddr}, {28'd0, vecs[i].ins[11:8]});
         if (vecs[i].chk_ops) begin
            check($sformatf("v%0d src", i), {16'd0, sourceData}, {16'd0, vecs[i].src});
            check($sformatf("v%0d dst", i), {16'd0, destData}, {16'd0, vecs[i].dst});
         end
         if (vecs[i].wr) writeback(vecs[i].ins[11:8], rf_model[vecs[i].ins[11:8]]);
         else tick();
         tick();
      end

      // RAW hazard: ADD R5,R3 then SUB R6,R5
      instr = 16'h0553; instrValid = 1'b1; outReady = 1'b1;
      tick();
      instr = 16'h0695;
      #1;
      check("raw stall1", {31'd0, instrReady}, 32'd0);
      tick();
      check("raw stall2", {31'd0, instrReady}, 32'd0);
      wbEn = 1'b1; wbAddr = 4'd5; wbData = 16'hABCD; rf_model[5] = 16'hABCD;
      #1;
`ifdef ALU_OPERAND_BYPASS_EN
      check("raw wb-cycle ready", {31'd0, instrReady}, 32'd1);
      tick();
      wbEn = 1'b0;
`else
      check("raw wb-cycle ready", {31'd0, instrReady}, 32'd0);
      tick();
      wbEn = 1'b0;
      check("raw idle outValid", {31'd0, outValid}, 32'd0);
      #1;
      check("raw ready after wb", {31'd0, instrReady}, 32'd1);
      tick();
`endif
      instrValid = 1'b0;
      check_out("raw issue", 8'h09, 16'hABCD, 16'h1106);
      writeback(4'd6, 16'h1106);
      tick();

      // Backpressure: held output stays stable for 3 cycles
      instr = 16'h0354; instrValid = 1'b1; outReady = 1'b0;
      tick();
      instr = 16'h12FD;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp%0d ready", k), {31'd0, instrReady}, 32'd0);
         check_out($sformatf("bp%0d", k), 8'h05, 16'h0002, 16'h0007);
         tick();
      end
      outReady = 1'b1;
      #1;
      check("bp release ready", {31'd0, instrReady}, 32'd1);
      tick();
      instrValid = 1'b0;
      check_out("bp next", 8'h10, 16'h0001, 16'h00FD);
      writeback(4'd3, 16'h0007);
      writeback(4'd2, 16'h0001);
      tick();

      // Flush: ADD R6,R3 held, then flushed; SUB R7,R6 must not stall
      instr = 16'h0653; instrValid = 1'b1; outReady = 1'b0;
      tick();
      check("fl held dest", {28'd0, outDestAddr}, 32'd6);
      instr = 16'h0796; flush = 1'b1;
      #1;
      check("fl cycle ready", {31'd0, instrReady}, 32'd0);
      tick();
      flush = 1'b0;
      check("fl outValid", {31'd0, outValid}, 32'd0);
      #1;
      check("fl no stall", {31'd0, instrReady}, 32'd1);
      tick();
      instrValid = 1'b0; outReady = 1'b1;
      check_out("fl follow", 8'h09, 16'h1106, 16'h1107);
      writeback(4'd7, 16'h1107);
      tick();

      // Asynchronous reset during a stall
      instr = 16'h0553; instrValid = 1'b1; outReady = 1'b0;
      tick();
      instr = 16'h0695;
      #1;
      check("ar pre outValid", {31'd0, outValid}, 32'd1);
      check("ar pre ready", {31'd0, instrReady}, 32'd0);
      #1;
      reset_n = 1'b0;
      #1;
      check("ar outValid", {31'd0, outValid}, 32'd0);
      check("ar ctl", {24'd0, operationControl}, 32'd0);
      check("ar src", {16'd0, sourceData}, 32'd0);
      check("ar ready", {31'd0, instrReady}, 32'd1);
      for (int i = 0; i < 16; i++) rf_model[i] = '0;
      tick();
      reset_n = 1'b1; outReady = 1'b1; instr = 16'h0354;
      #1;
      check("ar release ready", {31'd0, instrReady}, 32'd1);
      tick();
      instrValid = 1'b0;
      check_out("ar regs cleared", 8'h05, 16'h0000, 16'h0000);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
